mul_pipe: RTL and testbench

Parametrised, multi-cycle RISC-V M-extension multiplier for the EX stage, supporting MUL, MULH, MULHSU and MULHU. The operation is computed at the input and carried through STAGES register slices together with a valid bit and destination register index. Per-stage valid and rd values are exported to the hazard and forwarding unit. Adds stall (hold), flush (kill) and in-flight RAW hazard detection against the decode-stage Rs1/Rs2.

---
 rtl/mul_pkg.sv | 45 ++++
 rtl/mul_pipe_stage.sv | 56 +++++
 rtl/mul_pipe.sv | 98 +++++++++
 tb/tb_mul_pipe.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and arithmetic for the M-extension multiplier pipeline.
// Provides the op encoding, the stage-count ceiling and the product selector.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_t;

  localparam int unsigned MUL_MAX_STAGES = 8;
  localparam int unsigned MUL_MAX_XLEN   = 64;

  // Computes the XLEN-bit result selection for an op. Operands arrive
  // zero-extended to MUL_MAX_XLEN; xlen is the real operand width, and
  // signed operands are re-extended from bit xlen-1 here.
  function automatic logic [MUL_MAX_XLEN-1:0] mul_sel(
    input mul_op_t              op,
    input logic [MUL_MAX_XLEN-1:0] a,
    input logic [MUL_MAX_XLEN-1:0] b,
    input int unsigned          xlen
  );
    logic                        a_sgn;
    logic                        b_sgn;
    logic [5:0]                  msb;
    logic [2*MUL_MAX_XLEN-1:0]   a_ext;
    logic [2*MUL_MAX_XLEN-1:0]   b_ext;
    logic [2*MUL_MAX_XLEN-1:0]   prod;
    a_sgn = (op != MUL_OP_MULHU);
    b_sgn = (op == MUL_OP_MUL) || (op == MUL_OP_MULH);
    msb   = 6'(xlen - 1);
    a_ext = {{MUL_MAX_XLEN{1'b0}}, a};
    b_ext = {{MUL_MAX_XLEN{1'b0}}, b};
    if (a_sgn && a[msb]) a_ext = a_ext | ({(2*MUL_MAX_XLEN){1'b1}} << xlen);
    if (b_sgn && b[msb]) b_ext = b_ext | ({(2*MUL_MAX_XLEN){1'b1}} << xlen);
    // Low 2*xlen bits of the wide product equal the exact 2*xlen product.
    prod = a_ext * b_ext;
    if (op == MUL_OP_MUL) begin
      return prod[MUL_MAX_XLEN-1:0];
    end
    return MUL_MAX_XLEN'(prod >> xlen);
  endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// One pipeline slice holding {valid, rd, data}.
// Ports: clk, rst_n (async, active-low), en (advance), clr (kill valid),
//        valid_i/rd_i/data_i (upstream), valid_o/rd_o/data_o (registered).
module mul_pipe_stage
  import mul_pkg::*;
#(
  parameter int unsigned RW = 5,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic          valid_i,
  input  logic [RW-1:0] rd_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [RW-1:0] rd_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q, valid_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [DW-1:0] data_q, data_d;

  // Clear beats enable; payload is left as-is on clear.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (en) begin
      valid_d = valid_i;
      rd_d    = rd_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign rd_o    = rd_q;
  assign data_o  = data_q;

endmodule

// File: rtl/mul_pipe.sv
// Multi-cycle RISC-V MUL/MULH/MULHSU/MULHU unit for the EX stage.
// Result is computed at the input and carried through STAGES slices.
// Ports: clk, rst (async active-low); in_valid/in_ready/funct/a/b/rd (issue);
//        stall, flush (pipeline control); rs1_chk/rs2_chk (decode operands);
//        out_valid/result/out_rd (completion); stage_valid/stage_rd
//        (per-stage export); hazard_rs1/hazard_rs2 (in-flight RAW flags).
module mul_pipe
  import mul_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 4,
  parameter int unsigned REG_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              funct,
  input  logic [XLEN-1:0]         a,
  input  logic [XLEN-1:0]         b,
  input  logic [REG_W-1:0]        rd,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [REG_W-1:0]        rs1_chk,
  input  logic [REG_W-1:0]        rs2_chk,
  output logic                    out_valid,
  output logic [XLEN-1:0]         result,
  output logic [REG_W-1:0]        out_rd,
  output logic [STAGES-1:0]       stage_valid,
  output logic [STAGES*REG_W-1:0] stage_rd,
  output logic                    hazard_rs1,
  output logic                    hazard_rs2
);

  if (STAGES < 1 || STAGES > MUL_MAX_STAGES || XLEN > MUL_MAX_XLEN) begin : g_bad_cfg
    $error("mul_pipe: STAGES must be 1..8 and XLEN at most 64");
  end

  logic [XLEN-1:0]  sel_c;
  logic             s_valid [STAGES];
  logic [REG_W-1:0] s_rd    [STAGES];
  logic [XLEN-1:0]  s_data  [STAGES];

  assign sel_c    = XLEN'(mul_sel(mul_op_t'(funct), MUL_MAX_XLEN'(a),
                                  MUL_MAX_XLEN'(b), XLEN));
  assign in_ready = !stall;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             up_valid;
    logic [REG_W-1:0] up_rd;
    logic [XLEN-1:0]  up_data;

    // Stage 0 takes the issue port; later stages chain from their predecessor.
    if (i == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_rd    = rd;
      assign up_data  = sel_c;
    end else begin : g_body
      assign up_valid = s_valid[i-1];
      assign up_rd    = s_rd[i-1];
      assign up_data  = s_data[i-1];
    end

    mul_pipe_stage #(
      .RW (REG_W),
      .DW (XLEN)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst),
      .en      (!stall),
      .clr     (flush),
      .valid_i (up_valid),
      .rd_i    (up_rd),
      .data_i  (up_data),
      .valid_o (s_valid[i]),
      .rd_o    (s_rd[i]),
      .data_o  (s_data[i])
    );

    assign stage_valid[i]              = s_valid[i];
    assign stage_rd[i*REG_W +: REG_W]  = s_rd[i];
  end

  assign out_valid = s_valid[STAGES-1];
  assign result    = s_data[STAGES-1];
  assign out_rd    = s_rd[STAGES-1];

  // x0 is never a real destination, so a zero check index never matches.
  always_comb begin
    hazard_rs1 = 1'b0;
    hazard_rs2 = 1'b0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (s_valid[i] && (s_rd[i] == rs1_chk) && (rs1_chk != '0)) hazard_rs1 = 1'b1;
      if (s_valid[i] && (s_rd[i] == rs2_chk) && (rs2_chk != '0)) hazard_rs2 = 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_pipe.sv
// Directed self-checking bench for mul_pipe (XLEN=32, STAGES=4, REG_W=5).
module tb_mul_pipe;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned STAGES = 4;
  localparam int unsigned REG_W  = 5;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              funct;
  logic [XLEN-1:0]         a;
  logic [XLEN-1:0]         b;
  logic [REG_W-1:0]        rd;
  logic                    stall;
  logic                    flush;
  logic [REG_W-1:0]        rs1_chk;
  logic [REG_W-1:0]        rs2_chk;
  logic                    out_valid;
  logic [XLEN-1:0]         result;
  logic [REG_W-1:0]        out_rd;
  logic [STAGES-1:0]       stage_valid;
  logic [STAGES*REG_W-1:0] stage_rd;
  logic                    hazard_rs1;
  logic                    hazard_rs2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_pipe #(.XLEN(XLEN), .STAGES(STAGES), .REG_W(REG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .funct       (funct),
    .a           (a),
    .b           (b),
    .rd          (rd),
    .stall       (stall),
    .flush       (flush),
    .rs1_chk     (rs1_chk),
    .rs2_chk     (rs2_chk),
    .out_valid   (out_valid),
    .result      (result),
    .out_rd      (out_rd),
    .stage_valid (stage_valid),
    .stage_rd    (stage_rd),
    .hazard_rs1  (hazard_rs1),
    .hazard_rs2  (hazard_rs2)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] f, input logic [31:0] av,
                       input logic [31:0] bv, input logic [4:0] r);
    in_valid = 1'b1;
    funct    = f;
    a        = av;
    b        = bv;
    rd       = r;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    funct    = 2'b00;
    a        = '0;
    b        = '0;
    rd       = '0;
  endtask

  initial begin
    rst     = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    rs1_chk = '0;
    rs2_chk = '0;
    idle();
    step();
    step();
    check_eq("rst_out_valid",   64'(out_valid),   64'd0);
    check_eq("rst_result",      64'(result),      64'd0);
    check_eq("rst_out_rd",      64'(out_rd),      64'd0);
    check_eq("rst_stage_valid", 64'(stage_valid), 64'd0);
    check_eq("rst_stage_rd",    64'(stage_rd),    64'd0);
    check_eq("rst_in_ready",    64'(in_ready),    64'd1);
    rst = 1'b1;
    step();

    // Single MUL, walking valid bit
    offer(2'b00, 32'd7, 32'd6, 5'd5);
    step();
    idle();
    check_eq("t1_sv0",  64'(stage_valid), 64'b0001);
    check_eq("t1_rd0",  64'(stage_rd[4:0]), 64'd5);
    check_eq("t1_ov0",  64'(out_valid), 64'd0);
    step();
    check_eq("t1_sv1",  64'(stage_valid), 64'b0010);
    step();
    check_eq("t1_sv2",  64'(stage_valid), 64'b0100);
    check_eq("t1_ov2",  64'(out_valid), 64'd0);
    step();
    check_eq("t1_sv3",  64'(stage_valid), 64'b1000);
    check_eq("t1_ov3",  64'(out_valid), 64'd1);
    check_eq("t1_res",  64'(result), 64'd42);
    check_eq("t1_rd",   64'(out_rd), 64'd5);
    step();
    check_eq("t1_drain", 64'(stage_valid), 64'd0);

    // Back-to-back high-half ops
    offer(2'b01, 32'hFFFF_FFFE, 32'd3, 5'd1);
    step();
    offer(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    step();
    offer(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    step();
    idle();
    check_eq("t2_sv", 64'(stage_valid), 64'b0111);
    step();
    check_eq("t2_ov1",  64'(out_valid), 64'd1);
    check_eq("t2_mulh", 64'(result), 64'hFFFF_FFFF);
    check_eq("t2_rd1",  64'(out_rd), 64'd1);
    step();
    check_eq("t2_ov2",  64'(out_valid), 64'd1);
    check_eq("t2_mulhu", 64'(result), 64'hFFFF_FFFE);
    check_eq("t2_rd2",  64'(out_rd), 64'd2);
    step();
    check_eq("t2_ov3",  64'(out_valid), 64'd1);
    check_eq("t2_mulhsu", 64'(result), 64'hFFFF_FFFF);
    check_eq("t2_rd3",  64'(out_rd), 64'd3);
    step();
    check_eq("t2_drain", 64'(out_valid), 64'd0);

    // Stall for three cycles with the op at stage 1
    offer(2'b00, 32'd7, 32'd9, 5'd9);
    step();
    idle();
    step();
    check_eq("t3_sv_pre", 64'(stage_valid), 64'b0010);
    stall = 1'b1;
    offer(2'b00, 32'd1, 32'd1, 5'd20);
    #1;
    check_eq("t3_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t3_sv_hold", 64'(stage_valid), 64'b0010);
      check_eq("t3_rd_hold", 64'(stage_rd[9:5]), 64'd9);
    end
    stall = 1'b0;
    idle();
    #1;
    check_eq("t3_in_ready_rel", 64'(in_ready), 64'd1);
    step();
    check_eq("t3_ov_early", 64'(out_valid), 64'd0);
    step();
    check_eq("t3_ov",  64'(out_valid), 64'd1);
    check_eq("t3_res", 64'(result), 64'd63);
    check_eq("t3_rd",  64'(out_rd), 64'd9);
    // Holding the last stage keeps the result presented
    stall = 1'b1;
    step();
    check_eq("t3_ov_held", 64'(out_valid), 64'd1);
    check_eq("t3_res_held", 64'(result), 64'd63);
    stall = 1'b0;
    step();
    check_eq("t3_no_stalled_issue", 64'(stage_valid), 64'd0);

    // Flush with two ops in flight and one offered alongside
    offer(2'b00, 32'd2, 32'd2, 5'd4);
    step();
    offer(2'b00, 32'd3, 32'd3, 5'd6);
    step();
    check_eq("t4_sv_pre", 64'(stage_valid), 64'b0011);
    offer(2'b00, 32'd5, 32'd5, 5'd7);
    flush = 1'b1;
    stall = 1'b1;
    step();
    flush = 1'b0;
    stall = 1'b0;
    idle();
    check_eq("t4_sv_flush", 64'(stage_valid), 64'd0);
    check_eq("t4_ov_flush", 64'(out_valid), 64'd0);
    for (int i = 0; i < STAGES; i++) begin
      step();
      check_eq("t4_no_output", 64'(out_valid), 64'd0);
    end

    // Hazard detection
    offer(2'b00, 32'd1, 32'd1, 5'd12);
    step();
    idle();
    step();
    rs1_chk = 5'd12;
    rs2_chk = 5'd0;
    #1;
    check_eq("t5_haz1", 64'(hazard_rs1), 64'd1);
    check_eq("t5_haz2_zero", 64'(hazard_rs2), 64'd0);
    rs2_chk = 5'd12;
    #1;
    check_eq("t5_haz2", 64'(hazard_rs2), 64'd1);
    rs1_chk = 5'd13;
    #1;
    check_eq("t5_haz1_other", 64'(hazard_rs1), 64'd0);
    step();
    step();
    step();
    check_eq("t5_haz2_drained", 64'(hazard_rs2), 64'd0);
    offer(2'b00, 32'd1, 32'd1, 5'd0);
    step();
    idle();
    rs1_chk = 5'd0;
    rs2_chk = 5'd0;
    #1;
    check_eq("t5_sv_x0", 64'(stage_valid), 64'b0001);
    check_eq("t5_haz_x0", 64'(hazard_rs1), 64'd0);
    for (int i = 0; i < STAGES; i++) step();

    // Asynchronous reset mid-cycle with ops in flight
    offer(2'b00, 32'd4, 32'd4, 5'd1);
    step();
    offer(2'b00, 32'd5, 32'd5, 5'd2);
    step();
    offer(2'b00, 32'd6, 32'd6, 5'd3);
    step();
    idle();
    step();
    check_eq("t6_ov_pre",  64'(out_valid), 64'd1);
    check_eq("t6_res_pre", 64'(result), 64'd16);
    rs1_chk = 5'd2;
    #2;
    rst = 1'b0;
    #1;
    check_eq("t6_ov_rst",  64'(out_valid), 64'd0);
    check_eq("t6_sv_rst",  64'(stage_valid), 64'd0);
    check_eq("t6_res_rst", 64'(result), 64'd0);
    check_eq("t6_haz_rst", 64'(hazard_rs1), 64'd0);
    step();
    rst = 1'b1;
    for (int i = 0; i < STAGES + 2; i++) begin
      step();
      check_eq("t6_no_output", 64'(out_valid), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
